// File: rtl/multicast_input_buffer.sv
// multicast_input_buffer
//   Router input FIFO holding multicast flits. The head flit carries a
//   5-bit output-port mask {W,N,E,S,L} in its top bits; output ports
//   acknowledge it independently through 'served', and the flit leaves
//   the FIFO only once every port in its mask has taken it.
//
// Ports
//   ma_clk     in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   valid_in   in   upstream flit valid
//   data_in    in   [DATASIZE-1:0] flit, mask in [DATASIZE-1 -: 5]
//   full       out  back-pressure, high when count == DEPTH
//   label_out  out  [4:0] pending port mask of the head flit (0 if none)
//   data_out   out  [DATASIZE-1:0] head flit data (0 if none)
//   served     in   [4:0] per-port consume acknowledgement
//   count      out  [WIDTH:0] FIFO occupancy including the head entry
module multicast_input_buffer #(
  parameter int DEPTH    = 4,
  parameter int WIDTH    = 2,
  parameter int DATASIZE = 30
) (
  input  logic                ma_clk,
  input  logic                rst_n,
  input  logic                valid_in,
  input  logic [DATASIZE-1:0] data_in,
  output logic                full,
  output logic [4:0]          label_out,
  output logic [DATASIZE-1:0] data_out,
  input  logic [4:0]          served,
  output logic [WIDTH:0]      count
);

  localparam logic [WIDTH:0] DEPTH_C = (WIDTH+1)'(DEPTH);

  logic [DATASIZE-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH:0]      count_q, count_d;
  logic                head_valid_q, head_valid_d;
  logic [4:0]          pending_q, pending_d;

  logic                wr_en;
  logic                pop;
  logic                load;
  logic [4:0]          pend_left;

  // full depends only on registered occupancy, so a pop this cycle never
  // opens a slot for a write in the same cycle.
  assign full  = (count_q == DEPTH_C);
  assign wr_en = valid_in & ~full;

  // Served bits outside the pending mask simply fall away in the AND.
  assign pend_left = pending_q & ~served;
  assign pop       = head_valid_q & (pend_left == 5'b0);
  // Loading only from the idle-head state gives the one-cycle bubble after
  // every pop and lets a zero-mask head pop on the following edge.
  assign load      = ~head_valid_q & (count_q != '0);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    head_valid_d = head_valid_q;
    pending_d    = pending_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;

    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (pop && !wr_en) count_d = count_q - 1'b1;

    if (head_valid_q) begin
      pending_d = pend_left;
      if (pop) head_valid_d = 1'b0;
    end else if (load) begin
      pending_d    = mem_q[rd_ptr_q][DATASIZE-1 -: 5];
      head_valid_d = 1'b1;
    end
  end

  always_ff @(posedge ma_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      pending_q    <= 5'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      pending_q    <= pending_d;
    end
  end

  // Storage needs no reset: contents are only visible through the head,
  // which is gated by head_valid.
  always_ff @(posedge ma_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_in;
  end

  assign label_out = head_valid_q ? pending_q : 5'b0;
  assign data_out  = head_valid_q ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

endmodule

// File: tb/tb_multicast_input_buffer.sv
module tb_multicast_input_buffer;
  localparam int DEPTH = 4, WIDTH = 2, DATASIZE = 30;

  logic                ma_clk = 1'b0;
  logic                rst_n  = 1'b0;
  logic                valid_in = 1'b0;
  logic [DATASIZE-1:0] data_in  = '0;
  logic                full;
  logic [4:0]          label_out;
  logic [DATASIZE-1:0] data_out;
  logic [4:0]          served = 5'b0;
  logic [WIDTH:0]      count;

  int nchecks = 0;
  int nerr    = 0;

  multicast_input_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DATASIZE(DATASIZE)) dut (
    .ma_clk(ma_clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .full(full), .label_out(label_out), .data_out(data_out),
    .served(served), .count(count)
  );

  always #5 ma_clk = ~ma_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of stored flits plus the head's remaining
  // port set. The head becomes visible one edge after it is at the front
  // with nothing showing, and leaves once its port set is empty.
  logic [DATASIZE-1:0] mq[$];
  bit                  m_show = 0;
  logic [4:0]          m_left = 5'b0;

  always @(posedge ma_clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_show = 0;
      m_left = 5'b0;
    end else begin
      bit take;
      logic [DATASIZE-1:0] f;
      take = valid_in && (mq.size() < DEPTH);
      f    = data_in;
      if (m_show) begin
        m_left = m_left & ~served;
        if (m_left == 5'b0) begin
          mq.delete(0);
          m_show = 0;
        end
      end else if (mq.size() > 0) begin
        m_show = 1;
        m_left = mq[0][DATASIZE-1 -: 5];
      end
      if (take) mq.push_back(f);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge ma_clk) begin
    chk("cyc_count", 32'(count), 32'(mq.size()));
    chk("cyc_full",  32'(full),  32'(mq.size() == DEPTH));
    chk("cyc_label", 32'(label_out), m_show ? 32'(m_left) : 32'd0);
    chk("cyc_data",  32'(data_out),  m_show ? 32'(mq[0]) : 32'd0);
  end

  task automatic step();
    @(posedge ma_clk);
    #1;
  endtask

  task automatic put(input logic [4:0] m, input logic [24:0] d);
    valid_in = 1'b1;
    data_in  = {m, d};
  endtask

  initial begin
    logic [4:0] seq[$];
    int wi;
    bit seen;

    // Reset state
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_full",  32'(full), 0);
    chk("rst_label", 32'(label_out), 0);
    chk("rst_data",  32'(data_out), 0);
    step();
    rst_n = 1'b1;

    // Single unicast
    put(5'b00100, 25'h0ABCDEF);
    step();
    valid_in = 1'b0;
    chk("uni_cnt1", 32'(count), 1);
    chk("uni_lbl1", 32'(label_out), 0);
    step();
    chk("uni_lbl2", 32'(label_out), 32'(5'b00100));
    chk("uni_dat2", 32'(data_out), 32'({5'b00100, 25'h0ABCDEF}));
    served = 5'b00100;
    step();
    served = 5'b0;
    chk("uni_cnt3", 32'(count), 0);
    chk("uni_lbl3", 32'(label_out), 0);

    // Multicast split
    put(5'b10011, 25'h123);
    step();
    valid_in = 1'b0;
    step();
    chk("mc_lbl0", 32'(label_out), 32'(5'b10011));
    served = 5'b00001;
    step();
    chk("mc_lbl1", 32'(label_out), 32'(5'b10010));
    chk("mc_dat1", 32'(data_out), 32'({5'b10011, 25'h123}));
    served = 5'b10010;
    step();
    served = 5'b0;
    chk("mc_cnt", 32'(count), 0);
    chk("mc_lbl2", 32'(label_out), 0);

    // Fill, overflow attempt, pop, then accept the held flit
    for (int i = 0; i < 4; i++) begin
      put(5'b00001, 25'(i + 1));
      step();
    end
    chk("fill_cnt", 32'(count), 4);
    chk("fill_full", 32'(full), 1);
    put(5'b00001, 25'd5);
    step();
    chk("ovf_cnt", 32'(count), 4);
    served = 5'b00001;
    step();
    served = 5'b0;
    chk("pop_cnt", 32'(count), 3);
    chk("pop_full", 32'(full), 0);
    step();
    valid_in = 1'b0;
    chk("acc5_cnt", 32'(count), 4);
    chk("acc5_full", 32'(full), 1);
    served = 5'b00001;
    for (int i = 0; i < 20 && count != 0; i++) step();
    served = 5'b0;
    chk("drain_cnt", 32'(count), 0);

    // Wrap: six flits, serve whatever head is shown
    wi = 0;
    for (int c = 0; c < 60 && seq.size() < 6; c++) begin
      served = label_out;
      if (label_out != 5'b0) seq.push_back(label_out);
      if (wi < 6 && !full) begin
        put(5'(wi + 1), 25'(wi + 'h100));
        wi++;
      end else valid_in = 1'b0;
      step();
    end
    valid_in = 1'b0;
    served = 5'b0;
    chk("wrap_n", 32'(seq.size()), 6);
    for (int i = 0; i < 6 && i < seq.size(); i++)
      chk("wrap_lbl", 32'(seq[i]), 32'(i + 1));
    step();
    chk("wrap_cnt", 32'(count), 0);

    // Zero mask flit pops without showing a label
    put(5'b00000, 25'h77);
    step();
    valid_in = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (label_out != 5'b0) seen = 1;
      step();
    end
    chk("zero_lbl", 32'(seen), 0);
    chk("zero_cnt", 32'(count), 0);

    // Spurious serve
    put(5'b00001, 25'h55);
    step();
    valid_in = 1'b0;
    step();
    served = 5'b01000;
    step();
    chk("spur_lbl", 32'(label_out), 32'(5'b00001));
    served = 5'b00001;
    step();
    served = 5'b0;
    chk("spur_cnt", 32'(count), 0);

    // Reset mid-service
    put(5'b11000, 25'h1);
    step();
    put(5'b00010, 25'h2);
    step();
    put(5'b00100, 25'h3);
    step();
    valid_in = 1'b0;
    served = 5'b01000;
    step();
    served = 5'b0;
    chk("mid_cnt", 32'(count), 3);
    chk("mid_lbl", 32'(label_out), 32'(5'b10000));
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(count), 0);
    chk("arst_lbl", 32'(label_out), 0);
    chk("arst_full", 32'(full), 0);
    chk("arst_dat", 32'(data_out), 0);
    put(5'b00001, 25'h9);
    step();
    chk("inrst_cnt", 32'(count), 0);
    valid_in = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    step();
    chk("post_cnt", 32'(count), 0);
    chk("post_lbl", 32'(label_out), 0);

    @(negedge ma_clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
